// File: rtl/if_stage_pkg.sv
// Shared fetch-path constants: bus widths, zero/NOP words, reset level.
package if_stage_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned ENTRY_W     = INST_ADDR_W + INST_W;

  localparam logic [INST_ADDR_W-1:0] ZERO_WORD  = '0;
  localparam logic [INST_W-1:0]      NOP_WORD   = '0;
  localparam logic                   RST_ENABLE = 1'b1;

endpackage

// File: rtl/if_fifo.sv
// Instruction buffer: DEPTH-entry synchronous FIFO of {pc, inst} pairs.
// clear wins over push; the caller never pops when empty or pushes when full.
module if_fifo
  import if_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] data_i,
  input  logic               pop_i,
  output logic [CW-1:0]      count_o,
  output logic [ENTRY_W-1:0] head_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [CW-1:0]      count_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Entry storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem fetch FSM,
// instruction buffer, and stall/redirect handling toward decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned            DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_o,
  output logic [INST_ADDR_W-1:0] imem_addr_o,
  input  logic                   imem_rvalid_i,
  input  logic [INST_W-1:0]      imem_rdata_i,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [INST_ADDR_W-1:0] redirect_pc_i,
  output logic                   valid_o,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0]      inst_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e                 state_q;
  logic [INST_ADDR_W-1:0] fetch_pc_q;
  logic [INST_ADDR_W-1:0] req_addr_q;
  logic                   drop_q;

  logic [CW-1:0]          count;
  logic [ENTRY_W-1:0]     head;
  logic                   in_rst;
  logic                   buf_valid;
  logic                   push;
  logic                   pop;
  logic [CW:0]            occ_d;
  logic                   issue;
  logic [INST_ADDR_W-1:0] redirect_tgt;

  assign in_rst       = (rst == RST_ENABLE);
  assign buf_valid    = (count != '0);
  assign redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;

  // Buffer handshakes and the occupancy the buffer will have after this edge.
  always_comb begin
    push  = imem_rvalid_i && (state_q == S_WAIT) && !drop_q && !redirect_i;
    pop   = buf_valid && !stall_i && !redirect_i;
    occ_d = (CW+1)'(count) + (CW+1)'(push) - (CW+1)'(pop);
  end

  // A new request may launch when idle or as the outstanding one returns.
  // A dropped request still waiting blocks issue implicitly: WAIT without
  // rvalid never satisfies the launch condition.
  always_comb begin
    issue = !in_rst && !redirect_i && (occ_d < (CW+1)'(DEPTH)) &&
            ((state_q == S_IDLE) || (state_q == S_WAIT && imem_rvalid_i));
  end

  // Fetch FSM, PC and drop flag.
  always_ff @(posedge clk) begin
    if (in_rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= ZERO_WORD;
      drop_q     <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc_q <= redirect_tgt;
      if (state_q == S_WAIT) begin
        if (imem_rvalid_i) begin
          state_q <= S_IDLE;
          drop_q  <= 1'b0;
        end else begin
          drop_q  <= 1'b1;
        end
      end
    end else if (issue) begin
      state_q    <= S_WAIT;
      fetch_pc_q <= fetch_pc_q + 32'd4;
      req_addr_q <= fetch_pc_q;
      drop_q     <= 1'b0;
    end else if (state_q == S_WAIT && imem_rvalid_i) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
    end
  end

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (redirect_i),
    .push_i  (push),
    .data_i  ({req_addr_q, imem_rdata_i}),
    .pop_i   (pop),
    .count_o (count),
    .head_o  (head)
  );

  assign imem_req_o  = issue;
  assign imem_addr_o = fetch_pc_q;
  assign valid_o     = buf_valid && !in_rst;
  assign pc_o        = valid_o ? head[ENTRY_W-1:INST_W] : ZERO_WORD;
  assign inst_o      = valid_o ? head[INST_W-1:0]       : NOP_WORD;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage. Holds the program counter, issues one-at-a-time word fetches to instruction memory over a variable-latency req/rvalid interface, buffers returned instructions in a small FIFO, and presents {pc, inst} pairs to decode with stall and branch-redirect support. When no instruction is available it presents a NOP, so decode sees a bubble.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, instruction buffer entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- imem_req_o  out  1  fetch request, valid for one cycle per request
- imem_addr_o  out  32  word-aligned fetch address, valid with imem_req_o
- imem_rvalid_i  in  1  response strobe; ≥1 cycle after the request
- imem_rdata_i  in  32  instruction word, valid with imem_rvalid_i
- stall_i  in  1  decode cannot accept this cycle
- redirect_i  in  1  branch/jump taken; flush and refetch
- redirect_pc_i  in  32  new fetch address; bits [1:0] forced to 0
- valid_o  out  1  pc_o/inst_o hold a real instruction
- pc_o  out  32  PC of presented instruction; 0 when !valid_o
- inst_o  out  32  presented instruction; 32'h0 (NOP) when !valid_o

## Operation
- State: fetch_pc, FSM {IDLE, WAIT}, drop flag, FIFO of {pc, inst} with count 0..DEPTH.
- Pop: valid_o && !stall_i && !redirect_i; head entry removed at the clock edge.
- Push: imem_rvalid_i && state==WAIT && !drop && !redirect_i; entry {fetch-address of that request, imem_rdata_i}.
- Issue: imem_req_o=1 when (state==IDLE, or state==WAIT && imem_rvalid_i) && !redirect_i && (count + push − pop) < DEPTH && !(drop && state==WAIT && !imem_rvalid_i). imem_addr_o=fetch_pc. On issue: state→WAIT, fetch_pc←fetch_pc+4 (mod 2^32, wraps FFFF_FFFC→0).
- Response with no new issue: state→IDLE.
- Exactly one request outstanding at any time; imem_rvalid_i while IDLE is ignored.
- Redirect cycle: FIFO cleared, fetch_pc←{redirect_pc_i[31:2],2'b00}, no request issued, any response arriving this cycle discarded. If a request is outstanding and not returning this cycle, drop←1 and state stays WAIT; drop clears when that response arrives (response discarded, state→IDLE).
- Redirect while drop already set: fetch_pc updated, drop stays 1.
- stall_i holds head entry and outputs stable; fetching continues until FIFO full.
- FIFO full: no issue; empty: valid_o=0, outputs NOP/0.

## Timing
- Reset (rst=1 at edge): fetch_pc=RESET_PC, IDLE, drop=0, count=0; valid_o=0, pc_o=0, inst_o=0, imem_req_o=0 during reset cycle.
- First imem_req_o in first cycle with rst=0.
- Outputs valid_o/pc_o/inst_o driven from registered FIFO head; no rvalid→output bypass. rvalid in cycle N → valid_o in N+1.
- Zero-latency-after-request memory (rvalid in N+1 for req in N): back-to-back issue, throughput 1 instr/2 cycles? No: issue allowed in rvalid cycle, so 1 instr/cycle sustained.
- Redirect in N → imem_req_o at redirect target in N+1 (no outstanding) or the cycle after the dropped response returns.
- Reset mid-transaction: state cleared; late responses ignored because FSM is IDLE.

## Structure
- Shared defines file: InstAddrBus, InstBus, ZeroWord, NOP word, RstEnable; no new package types.
- Sub-module if_fifo: DEPTH-entry synchronous FIFO of 64-bit {pc,inst}, push/pop/clear, count, head outputs; clear has priority over push.
- FSM, issue logic and PC arithmetic in if_stage.

## Test plan
- Reset, RESET_PC=0, 1-cycle memory returning addr-as-data -> req at 0,4,8… each cycle; valid_o from cycle 2, pc_o/inst_o = 0,4,8 consecutively.
- stall_i held 5 cycles at pc_o=8 -> outputs frozen at 8; exactly DEPTH entries buffered; no req while full; release -> 8,C,10 without gaps.
- Redirect to 32'h0000_0103 with request outstanding, 3-cycle latency -> pending response discarded, next req addr 0x100, first valid_o pc_o=0x100.
- Redirect coinciding with rvalid -> that instruction never appears; next req at target in following cycle.
- fetch_pc=FFFF_FFFC -> next req addr 0x0000_0000.
- rst asserted while WAIT, rvalid arrives cycle after -> ignored; first output pc_o=RESET_PC.
